// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one pipeline memory op into a single bus access,
// with alignment checks, byte-lane steering, load extension and a bus timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [2:0]  lsu_func3,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic        lsu_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          timeout;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [2:0]    func3_q;
  logic          we_q;
  logic          misalign_q;
  logic          err_q;
  logic          illegal_in;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // Bad func3 for the direction, or a half/word address not naturally aligned.
  always_comb begin
    illegal_in = 1'b0;
    if (lsu_we)
      illegal_in = (lsu_func3 > 3'd2);
    else
      illegal_in = (lsu_func3 == 3'b011) || (lsu_func3 == 3'b110) || (lsu_func3 == 3'b111);
    case (lsu_func3[1:0])
      2'b01:   if (lsu_addr[0]) illegal_in = 1'b1;
      2'b10:   if (lsu_addr[1:0] != 2'b00) illegal_in = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (func3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      2'b11:   byte_sel = mem_rdata[31:24];
      default: ;
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  assign cnt_next = cnt + 1'b1;
  assign timeout  = (cnt_next == TLIM);

  // A completing response always wins over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      func3_q    <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            misalign_q <= illegal_in;
            err_q      <= 1'b0;
            if (illegal_in) begin
              state <= DONE;
            end else begin
              addr_q  <= lsu_addr;
              wdata_q <= lsu_wdata;
              func3_q <= lsu_func3;
              we_q    <= lsu_we;
              cnt     <= '0;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt_next;
          if (mem_gnt && we_q) begin
            state <= DONE;
          end else if (mem_gnt && mem_rvalid) begin
            rdata_q <= load_ext;
            state   <= DONE;
          end else if (timeout) begin
            err_q <= 1'b1;
            if (!we_q) rdata_q <= '0;
            state <= DONE;
          end else if (mem_gnt) begin
            state <= RSP;
          end
        end
        RSP: begin
          cnt <= cnt_next;
          if (mem_rvalid) begin
            rdata_q <= load_ext;
            state   <= DONE;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are only meaningful while requesting, so they read zero otherwise.
  assign mem_req      = (state == REQ);
  assign mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_we       = mem_req & we_q;
  assign mem_be       = mem_req ? be : 4'b0000;
  assign mem_wdata    = mem_req ? wdata_rep : 32'd0;
  assign lsu_done     = (state == DONE);
  assign lsu_misalign = lsu_done & misalign_q;
  assign lsu_err      = lsu_done & err_q;
  assign lsu_rdata    = rdata_q;
  assign lsu_stall    = lsu_valid & ~rst & (state != DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized
// ops against a behavioural model of sizing, extension, latency and timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_func3;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_rdata = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_func3(lsu_func3),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=expired exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One memory op; g = REQ cycles without grant, r = RSP cycles until rvalid (0 = with grant).
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [31:0] word, input int g, input int r);
    bit          legal, granted, finished;
    int          bus, lat, reqs, cyc, k, j, stall_bad, bus_bad;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, v;

    if (we) legal = (f3 <= 3'd2);
    else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (f3[1:0] == 2'd1 && addr % 2 != 0) legal = 0;
    if (f3[1:0] == 2'd2 && addr % 4 != 0) legal = 0;

    case (f3[1:0])
      2'd0: begin
        exp_be = 4'(1 << addr[1:0]);
        exp_wd = (wdata & 32'hFF) * 32'h01010101;
        v = (word >> (8 * addr[1:0])) & 32'hFF;
        if (!f3[2] && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        exp_be = 4'(3 << (addr[1] * 2));
        exp_wd = (wdata & 32'hFFFF) * 32'h00010001;
        v = (word >> (16 * addr[1])) & 32'hFFFF;
        if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      default: begin
        exp_be = 4'hF;
        exp_wd = wdata;
        v = word;
      end
    endcase

    bus = we ? g + 1 : g + 1 + r;
    exp_err = 0;
    if (!legal) begin
      lat = 1; reqs = 0;
    end else if (bus <= 16) begin
      lat = bus + 1; reqs = g + 1;
    end else begin
      lat = 17; reqs = (g + 1 < 16) ? g + 1 : 16; exp_err = 1;
    end

    @(negedge clk);
    checkOutput("rdata_hold", lsu_rdata, model_rdata);
    lsu_valid = 1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_func3 = f3;
    mem_gnt = 0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;

    cyc = 0; k = 0; j = 0; granted = 0; finished = 0; stall_bad = 0; bus_bad = 0;
    while (!finished && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (lsu_done) begin
        finished = 1;
        checkOutput("latency", cyc, lat);
        checkOutput("misalign", lsu_misalign, !legal);
        checkOutput("err", lsu_err, exp_err);
        checkOutput("req_cycles", k, reqs);
        checkOutput("stall_done", lsu_stall, 0);
        checkOutput("stall_busy", stall_bad, 0);
        checkOutput("bus_fields", bus_bad, 0);
        if (legal && !we) model_rdata = exp_err ? 32'd0 : v;
        checkOutput("rdata", lsu_rdata, model_rdata);
        lsu_valid = 0;
        mem_rvalid = 1;
      end else begin
        if (lsu_stall !== 1'b1) stall_bad++;
        if (mem_req) begin
          k++;
          if (mem_addr !== (addr & 32'hFFFFFFFC) || mem_be !== exp_be || mem_we !== we) bus_bad++;
          if (we && mem_wdata !== exp_wd) bus_bad++;
          if (k == g + 1) begin
            mem_gnt = 1; granted = 1;
            if (!we && r == 0) begin mem_rvalid = 1; mem_rdata = word; end
          end
        end else if (granted) begin
          j++;
          if (j == r) begin mem_rvalid = 1; mem_rdata = word; end
        end
      end
    end
    if (!finished) begin
      checkOutput("done_wait", cyc, lat);
      lsu_valid = 0;
    end
  endtask

  // Reset asserted mid-access must kill the bus request and stall at once.
  task automatic resetMidBus(input bit in_rsp);
    @(negedge clk);
    lsu_valid = 1; lsu_we = 0; lsu_addr = 32'h40; lsu_func3 = 3'b010;
    mem_gnt = 0; mem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_gnt = in_rsp && c == 0 && mem_req;
    end
    checkOutput("pre_rst_req", mem_req, !in_rsp);
    #2 rst = 1;
    #1 checkOutput("rst_async", {mem_req, lsu_stall, lsu_done, lsu_rdata}, 0);
    mem_gnt = 0;
    @(negedge clk);
    rst = 0; lsu_valid = 0;
    model_rdata = 32'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("no_done_after_rst", {lsu_done, mem_req}, 0);
    end
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int          g, r;

    rst = 1; lsu_valid = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_func3 = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outs", {lsu_stall, lsu_done, lsu_rdata, lsu_misalign, lsu_err,
                               mem_req, mem_addr, mem_we, mem_be, mem_wdata}, 0);
    rst = 0;

    applyStimulus(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
    applyStimulus(0, 32'h21, 32'h0, 3'b000, 32'h80FF7F01, 0, 0);
    checkOutput("lb_21", lsu_rdata, 32'h0000007F);
    applyStimulus(0, 32'h23, 32'h0, 3'b000, 32'h80FF7F01, 1, 1);
    checkOutput("lb_23", lsu_rdata, 32'hFFFFFF80);
    applyStimulus(0, 32'h22, 32'h0, 3'b100, 32'h80FF7F01, 0, 2);
    checkOutput("lbu_22", lsu_rdata, 32'h000000FF);
    applyStimulus(0, 32'h22, 32'h0, 3'b001, 32'h80FF7F01, 2, 0);
    checkOutput("lh_22", lsu_rdata, 32'hFFFF80FF);
    applyStimulus(0, 32'h20, 32'h0, 3'b101, 32'h80FF7F01, 0, 0);
    checkOutput("lhu_20", lsu_rdata, 32'h00007F01);
    applyStimulus(1, 32'h06, 32'h1234ABCD, 3'b001, 32'h0, 0, 0);
    applyStimulus(0, 32'h06, 32'h0, 3'b010, 32'h0, 0, 0);
    applyStimulus(0, 32'h100, 32'h0, 3'b010, 32'hCAFEF00D, 3, 2);
    applyStimulus(0, 32'h104, 32'h0, 3'b010, 32'h12345678, 100, 0);
    applyStimulus(1, 32'h08, 32'h55AA55AA, 3'b010, 32'h0, 15, 0);
    applyStimulus(1, 32'h0C, 32'h55AA55AA, 3'b000, 32'h0, 16, 0);
    applyStimulus(0, 32'h30, 32'h0, 3'b010, 32'h0BADBEEF, 0, 15);
    applyStimulus(0, 32'h34, 32'h0, 3'b010, 32'h0BADBEEF, 0, 16);
    applyStimulus(0, 32'h38, 32'h0, 3'b001, 32'h9876FEDC, 15, 0);
    applyStimulus(1, 32'h3C, 32'h0, 3'b011, 32'h0, 0, 0);

    applyStimulus(0, 32'h44, 32'h0, 3'b010, 32'hA5A5A5A5, 0, 0);
    resetMidBus(1);
    applyStimulus(0, 32'h48, 32'h0, 3'b010, 32'h5A5A5A5A, 0, 0);
    resetMidBus(0);

    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
      r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 18)) : int'($urandom_range(0, 3));
      applyStimulus(we, addr, $urandom, f3, $urandom, g, r);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the bus cycles allowed per access (REQ+RSP states) before error.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 lsu_valid  in  1  pipeline memory-op request, held until lsu_done.
REQ-005 lsu_we  in  1  1=store, 0=load.
REQ-006 lsu_addr  in  32  byte address from ALU.
REQ-007 lsu_wdata  in  32  store data (rs2).
REQ-008 lsu_func3  in  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 lsu_stall  out  1  freeze pipeline.
REQ-010 lsu_done  out  1  one-cycle completion pulse.
REQ-011 lsu_rdata  out  32  extended load result.
REQ-012 lsu_misalign  out  1  misaligned/illegal-func3 flag, valid with lsu_done.
REQ-013 lsu_err  out  1  bus timeout flag, valid with lsu_done.
REQ-014 mem_req  out  1  bus request.
REQ-015 mem_gnt  in  1  bus accepts request.
REQ-016 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-017 mem_we  out  1  write strobe.
REQ-018 mem_be  out  4  byte-lane enables.
REQ-019 mem_wdata  out  32  lane-replicated store data.
REQ-020 mem_rvalid  in  1  read data valid.
REQ-021 mem_rdata  in  32  raw read word.

Function
REQ-022 FSM states SHALL be IDLE, REQ, RSP, DONE; lsu_stall = lsu_valid AND state!=DONE (combinational).
REQ-023 IDLE + lsu_valid: illegal func3 (load 011/110/111; store other than 000/001/010) or misaligned (half: addr[0]=1; word: addr[1:0]!=0) SHALL go to DONE with lsu_misalign=1, no mem_req; else capture addr/wdata/func3/we, go REQ.
REQ-024 REQ: mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt sampled high.
REQ-025 REQ + mem_gnt: store -> DONE; load with mem_rvalid same cycle -> capture data, DONE; load otherwise -> RSP.
REQ-026 RSP: mem_req=0; on mem_rvalid capture extended data -> DONE; mem_rvalid outside REQ/RSP SHALL be ignored.
REQ-027 DONE: lsu_done=1 for exactly one cycle, then IDLE unconditionally; new request accepted no earlier than the following IDLE cycle.
REQ-028 Byte enables: byte = 4'b0001<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111; same for loads and stores.
REQ-029 Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-030 Load data: lane selected by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-031 lsu_rdata SHALL hold its value until the next completing load; stores and faults SHALL leave it unchanged except timeout on a load, which SHALL write 0.
REQ-032 Timeout counter SHALL clear on IDLE->REQ, increment each REQ/RSP cycle; reaching TIMEOUT_CYCLES -> DONE with lsu_err=1, mem_req dropped.
REQ-033 Simultaneous mem_rvalid (or mem_gnt for stores) and timeout SHALL complete normally, lsu_err=0.
REQ-034 Minimum latency, zero-wait memory: accept cycle N, mem_req cycle N+1, lsu_done cycle N+2.

Reset
REQ-035 rst=1 SHALL immediately force state IDLE, counter 0, all outputs 0 (lsu_rdata 0), including mid-transaction; mem_req SHALL drop asynchronously.
REQ-036 After rst deassert, first request SHALL be accepted on the first rising edge with lsu_valid=1.

Verification
REQ-037 SW addr 0x10 wdata 0xDEADBEEF, gnt same cycle -> mem_addr 0x10, be 1111, wdata 0xDEADBEEF, done at N+2.
REQ-038 mem_rdata 0x80FF7F01 at addr 0x20: LB @0x21 -> 0xFFFFFF7F? no: lane1=0x7F -> 0x0000007F; LB @0x23 -> 0xFFFFFF80; LBU @0x22 -> 0x000000FF; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
REQ-039 SH addr 0x06 wdata 0x1234ABCD -> be 1100, mem_wdata 0xABCDABCD; LW addr 0x06 -> lsu_misalign=1, no mem_req, done next cycle.
REQ-040 gnt delayed 3 cycles, rvalid 2 cycles later -> mem_req held 4 cycles stable, stall high throughout, single done pulse.
REQ-041 Never grant -> lsu_err=1 after 16 bus cycles, lsu_rdata 0; assert rst mid-RSP -> mem_req/stall low immediately, no done pulse.
